// File: rtl/clk_or_en_idle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_or_en_idle_ctrl
// Purpose  : Enable generator for an OR-type clock gate. Counts consecutive
//            idle cycles on the free-running clock and stops the downstream
//            clock once a programmable threshold is reached. Restarts it on
//            activity or a wake request. Acknowledges the wake request after
//            a settle period.
// Ports    : clk            free-running clock (never gated by o_gate_en)
//            rst            synchronous active-high reset
//            i_busy         gated-domain activity indicator
//            i_wake_req     level wake request, held until o_wake_ack
//            i_force_on     debug override, keeps the clock running
//            i_idle_thresh  idle cycles before gating (0 = never gate)
//            o_gate_en      OR-gate enable, 1 = clock held high
//            o_gated        high while in the GATED state
//            o_wake_ack     single-cycle acknowledge of i_wake_req
//            o_gate_cnt     saturating count of RUN->GATED transitions
// Revision : 1.0 - initial release
// ============================================================================
module clk_or_en_idle_ctrl #(
  parameter int IDLE_CNT_W = 8,
  parameter int WAKE_DLY   = 2,   // legal range 1..15
  parameter int GCNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_busy,
  input  logic                  i_wake_req,
  input  logic                  i_force_on,
  input  logic [IDLE_CNT_W-1:0] i_idle_thresh,
  output logic                  o_gate_en,
  output logic                  o_gated,
  output logic                  o_wake_ack,
  output logic [GCNT_W-1:0]     o_gate_cnt
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_GATED = 2'd1,
    S_WAKE  = 2'd2
  } state_t;

  localparam logic [IDLE_CNT_W-1:0] c_IDLE_MAX  = '1;
  localparam logic [GCNT_W-1:0]     c_GCNT_MAX  = '1;
  localparam logic [3:0]            c_WAKE_LAST = 4'(WAKE_DLY - 1);

  state_t                r_state;
  logic [IDLE_CNT_W-1:0] r_idle_cnt;
  logic [3:0]            r_wake_tmr;
  logic                  r_gate_en;
  logic                  r_gated;
  logic                  r_wake_ack;
  logic [GCNT_W-1:0]     r_gate_cnt;
  logic                  r_ack_armed;

  state_t                w_state_nxt;
  logic [IDLE_CNT_W-1:0] w_idle_nxt;
  logic [3:0]            w_tmr_nxt;
  logic                  w_gate_en_nxt;
  logic                  w_gated_nxt;
  logic [GCNT_W-1:0]     w_cnt_nxt;
  logic                  w_wake_exit;
  logic                  w_ack_fire;
  logic                  w_armed_nxt;

  logic                  w_act;
  logic [IDLE_CNT_W:0]   w_idle_plus1;
  logic                  w_thresh_hit;
  logic [IDLE_CNT_W-1:0] w_idle_sat_inc;
  logic [GCNT_W-1:0]     w_cnt_sat_inc;

  assign w_act = i_busy | i_wake_req | i_force_on;

  // One extra bit so a saturated idle count still compares as "past" any
  // threshold instead of wrapping to zero.
  assign w_idle_plus1   = {1'b0, r_idle_cnt} + {{IDLE_CNT_W{1'b0}}, 1'b1};
  assign w_thresh_hit   = (i_idle_thresh != '0) && !w_act &&
                          (w_idle_plus1 >= {1'b0, i_idle_thresh});
  assign w_idle_sat_inc = (r_idle_cnt == c_IDLE_MAX) ? r_idle_cnt
                                                     : w_idle_plus1[IDLE_CNT_W-1:0];
  assign w_cnt_sat_inc  = (r_gate_cnt == c_GCNT_MAX) ? r_gate_cnt
                                                     : r_gate_cnt + GCNT_W'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_idle_nxt    = r_idle_cnt;
    w_tmr_nxt     = r_wake_tmr;
    w_gate_en_nxt = r_gate_en;
    w_gated_nxt   = r_gated;
    w_cnt_nxt     = r_gate_cnt;
    w_wake_exit   = 1'b0;

    case (r_state)
      S_RUN: begin
        w_gate_en_nxt = 1'b0;
        w_gated_nxt   = 1'b0;
        if (w_act) begin
          w_idle_nxt = '0;
        end else if (w_thresh_hit) begin
          w_state_nxt   = S_GATED;
          w_gate_en_nxt = 1'b1;
          w_gated_nxt   = 1'b1;
          w_idle_nxt    = '0;
          w_cnt_nxt     = w_cnt_sat_inc;
        end else begin
          w_idle_nxt = w_idle_sat_inc;
        end
      end

      S_GATED: begin
        // Clearing the threshold while gated is treated as a release.
        if (w_act || (i_idle_thresh == '0)) begin
          w_state_nxt   = S_WAKE;
          w_gate_en_nxt = 1'b0;
          w_gated_nxt   = 1'b0;
          w_tmr_nxt     = '0;
        end
      end

      S_WAKE: begin
        // No gating path out of WAKE: the settle period always completes.
        w_gate_en_nxt = 1'b0;
        w_gated_nxt   = 1'b0;
        w_tmr_nxt     = r_wake_tmr + 4'd1;
        if (r_wake_tmr == c_WAKE_LAST) begin
          w_state_nxt = S_RUN;
          w_idle_nxt  = '0;
          w_wake_exit = 1'b1;
        end
      end

      default: begin
        w_state_nxt   = S_RUN;
        w_gate_en_nxt = 1'b0;
        w_gated_nxt   = 1'b0;
        w_idle_nxt    = '0;
      end
    endcase
  end

  // The ack only fires once per request level: armed again when the
  // requester drops wake_req. A request withdrawn mid-WAKE never acks.
  assign w_ack_fire  = i_wake_req && r_ack_armed &&
                       ((r_state == S_RUN) || w_wake_exit);
  assign w_armed_nxt = !i_wake_req ? 1'b1 : (w_ack_fire ? 1'b0 : r_ack_armed);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_idle_cnt  <= '0;
      r_wake_tmr  <= '0;
      r_gate_en   <= 1'b0;
      r_gated     <= 1'b0;
      r_wake_ack  <= 1'b0;
      r_gate_cnt  <= '0;
      r_ack_armed <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_idle_cnt  <= w_idle_nxt;
      r_wake_tmr  <= w_tmr_nxt;
      r_gate_en   <= w_gate_en_nxt;
      r_gated     <= w_gated_nxt;
      r_wake_ack  <= w_ack_fire;
      r_gate_cnt  <= w_cnt_nxt;
      r_ack_armed <= w_armed_nxt;
    end
  end

  assign o_gate_en  = r_gate_en;
  assign o_gated    = r_gated;
  assign o_wake_ack = r_wake_ack;
  assign o_gate_cnt = r_gate_cnt;

endmodule
`default_nettype wire

// File: tb/tb_clk_or_en_idle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_or_en_idle_ctrl
// Purpose  : Self-checking bench for clk_or_en_idle_ctrl. A main instance
//            uses default parameters; a second narrow-counter instance
//            exercises gate_cnt saturation in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_or_en_idle_ctrl;

  localparam int WD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy = 1'b0;
  logic        wake_req = 1'b0;
  logic        force_on = 1'b0;
  logic [7:0]  thresh = 8'd0;
  logic        gate_en, gated, wake_ack;
  logic [15:0] gate_cnt;

  logic        s_rst = 1'b1;
  logic        s_busy = 1'b0;
  logic        s_gate_en, s_gated, s_ack;
  logic [2:0]  s_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clk_or_en_idle_ctrl #(.IDLE_CNT_W(8), .WAKE_DLY(WD), .GCNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .i_busy(busy), .i_wake_req(wake_req),
    .i_force_on(force_on), .i_idle_thresh(thresh),
    .o_gate_en(gate_en), .o_gated(gated), .o_wake_ack(wake_ack),
    .o_gate_cnt(gate_cnt)
  );

  clk_or_en_idle_ctrl #(.IDLE_CNT_W(8), .WAKE_DLY(1), .GCNT_W(3)) u_dut_sat (
    .clk(clk), .rst(s_rst), .i_busy(s_busy), .i_wake_req(1'b0),
    .i_force_on(1'b0), .i_idle_thresh(8'd1),
    .o_gate_en(s_gate_en), .o_gated(s_gated), .o_wake_ack(s_ack),
    .o_gate_cnt(s_cnt)
  );

  // Reference model: clock-stopped flag, remaining settle cycles, plain
  // integer counters clamped with min().
  int m_idle, m_cnt, m_wake_left;
  bit m_stopped, m_ack, m_armed;

  task automatic model_edge();
    bit act, was_run, exiting;
    act     = busy | wake_req | force_on;
    was_run = !m_stopped && (m_wake_left == 0);
    exiting = 1'b0;
    if (rst) begin
      m_idle = 0; m_cnt = 0; m_wake_left = 0;
      m_stopped = 0; m_ack = 0; m_armed = 1;
      return;
    end
    if (m_wake_left > 0) begin
      m_wake_left--;
      if (m_wake_left == 0) begin
        m_idle  = 0;
        exiting = 1'b1;
      end
    end else if (m_stopped) begin
      if (act || thresh == 0) begin
        m_stopped   = 0;
        m_wake_left = WD;
      end
    end else if (act) begin
      m_idle = 0;
    end else if (thresh != 0 && m_idle + 1 >= int'(thresh)) begin
      m_stopped = 1;
      m_idle    = 0;
      m_cnt     = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
    end else begin
      m_idle = (m_idle + 1 > 255) ? 255 : m_idle + 1;
    end
    m_ack = wake_req && m_armed && (was_run || exiting);
    if (!wake_req) m_armed = 1;
    else if (m_ack) m_armed = 0;
  endtask

  function automatic logic [18:0] model_vec();
    return {m_stopped, m_stopped, m_ack, 16'(m_cnt)};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; busy = 1'b0; wake_req = 1'b0; force_on = 1'b0; thresh = 8'd0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; thresh = 8'd4;
    step(); step();
    checks++;
    if ({gate_en, gated, wake_ack, gate_cnt} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {gate_en, gated, wake_ack, gate_cnt});
    end
    checks++;
    if ({gate_en, gated, wake_ack, gate_cnt} !== model_vec()) begin
      errors++;
      $display("FAIL reset_model: got %h want %h", {gate_en, gated, wake_ack, gate_cnt}, model_vec());
    end
    rst = 1'b0;
  endtask

  task automatic test_idle_gate();
    do_reset();
    thresh = 8'd4;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (gate_en !== (i == 4)) begin
        errors++;
        $display("FAIL idle_gate_edge%0d: gate_en=%b want %b", i, gate_en, (i == 4));
      end
    end
    checks++;
    if (gated !== 1'b1 || gate_cnt !== 16'd1) begin
      errors++;
      $display("FAIL idle_gate_status: gated=%b cnt=%0d want 1/1", gated, gate_cnt);
    end
  endtask

  task automatic test_busy_interrupt();
    do_reset();
    thresh = 8'd4;
    step(); step();
    busy = 1'b1;
    step();
    busy = 1'b0;
    checks++;
    if (gate_en !== 1'b0) begin
      errors++;
      $display("FAIL busy_hold: gate_en=%b want 0", gate_en);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (gate_en !== (i == 4)) begin
        errors++;
        $display("FAIL busy_regate_edge%0d: gate_en=%b want %b", i, gate_en, (i == 4));
      end
    end
    checks++;
    if (gate_cnt !== 16'd1) begin
      errors++;
      $display("FAIL busy_cnt: cnt=%0d want 1", gate_cnt);
    end
  endtask

  task automatic test_wake_from_gated();
    do_reset();
    thresh = 8'd4;
    repeat (4) step();
    wake_req = 1'b1;
    step();
    checks++;
    if (gate_en !== 1'b0 || wake_ack !== 1'b0) begin
      errors++;
      $display("FAIL wake_T: gate_en=%b ack=%b want 0/0", gate_en, wake_ack);
    end
    step();
    checks++;
    if (wake_ack !== 1'b0) begin
      errors++;
      $display("FAIL wake_T1: ack=%b want 0", wake_ack);
    end
    step();
    checks++;
    if (wake_ack !== 1'b1 || gated !== 1'b0) begin
      errors++;
      $display("FAIL wake_T2: ack=%b gated=%b want 1/0", wake_ack, gated);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (wake_ack !== 1'b0 || gate_en !== 1'b0) begin
        errors++;
        $display("FAIL wake_hold%0d: ack=%b gate_en=%b want 0/0", i, wake_ack, gate_en);
      end
    end
    wake_req = 1'b0;
    step();
  endtask

  task automatic test_wake_in_run();
    do_reset();
    thresh = 8'd4;
    step();
    wake_req = 1'b1;
    step();
    checks++;
    if (wake_ack !== 1'b1 || gate_en !== 1'b0) begin
      errors++;
      $display("FAIL run_ack: ack=%b gate_en=%b want 1/0", wake_ack, gate_en);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (wake_ack !== 1'b0 || gate_en !== 1'b0) begin
        errors++;
        $display("FAIL run_ack_hold%0d: ack=%b gate_en=%b want 0/0", i, wake_ack, gate_en);
      end
    end
    wake_req = 1'b0;
    step();
  endtask

  task automatic test_thresh_zero();
    do_reset();
    thresh = 8'd4;
    repeat (4) step();
    thresh = 8'd0;
    step();
    checks++;
    if (gate_en !== 1'b0) begin
      errors++;
      $display("FAIL thr0_exit: gate_en=%b want 0", gate_en);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (gate_en !== 1'b0 || {gate_en, gated, wake_ack, gate_cnt} !== model_vec()) begin
        errors++;
        $display("FAIL thr0_idle%0d: got %h want %h", i, {gate_en, gated, wake_ack, gate_cnt}, model_vec());
      end
    end
  endtask

  task automatic test_force_on();
    do_reset();
    thresh = 8'd2;
    repeat (2) step();
    checks++;
    if (gate_en !== 1'b1) begin
      errors++;
      $display("FAIL force_pre: gate_en=%b want 1", gate_en);
    end
    force_on = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (gate_en !== 1'b0 || wake_ack !== 1'b0) begin
        errors++;
        $display("FAIL force_hold%0d: gate_en=%b ack=%b want 0/0", i, gate_en, wake_ack);
      end
    end
    force_on = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({gate_en, gated, wake_ack, gate_cnt} !== model_vec()) begin
        errors++;
        $display("FAIL force_release%0d: got %h want %h", i, {gate_en, gated, wake_ack, gate_cnt}, model_vec());
      end
    end
  endtask

  task automatic test_reset_mid_gated();
    do_reset();
    thresh = 8'd1;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k < 5) begin
        busy = 1'b1; step();
        busy = 1'b0; step(); step();
      end
    end
    checks++;
    if (gate_cnt !== 16'd5 || gated !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst: cnt=%0d gated=%b want 5/1", gate_cnt, gated);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({gate_en, gated, wake_ack, gate_cnt} !== 19'd0) begin
      errors++;
      $display("FAIL mid_rst: got %h want 0", {gate_en, gated, wake_ack, gate_cnt});
    end
    rst = 1'b0;
  endtask

  task automatic test_idle_saturate();
    do_reset();
    repeat (300) step();
    thresh = 8'd255;
    step();
    checks++;
    if (gate_en !== 1'b1 || {gate_en, gated, wake_ack, gate_cnt} !== model_vec()) begin
      errors++;
      $display("FAIL idle_sat: got %h want %h", {gate_en, gated, wake_ack, gate_cnt}, model_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    thresh = 8'd3;
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      busy     = ($urandom_range(0, 5) == 0);
      force_on = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) wake_req = ~wake_req;
      if ($urandom_range(0, 49) == 0) thresh = 8'($urandom_range(0, 6));
      step();
      checks++;
      if ({gate_en, gated, wake_ack, gate_cnt} !== model_vec()) begin
        errors++;
        $display("FAIL random_cyc%0d: got %h want %h", i, {gate_en, gated, wake_ack, gate_cnt}, model_vec());
      end
    end
    rst = 1'b0; busy = 1'b0; force_on = 1'b0; wake_req = 1'b0;
  endtask

  task automatic test_cnt_saturation();
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (s_gate_en !== 1'b1 || int'(s_cnt) != ((k > 7) ? 7 : k)) begin
        errors++;
        $display("FAIL cnt_sat%0d: gate_en=%b cnt=%0d want 1/%0d", k, s_gate_en, s_cnt, (k > 7) ? 7 : k);
      end
      s_busy = 1'b1; step();
      s_busy = 1'b0; step();
    end
  endtask

  initial begin
    test_reset();
    test_idle_gate();
    test_busy_interrupt();
    test_wake_from_gated();
    test_wake_in_run();
    test_thresh_zero();
    test_force_on();
    test_reset_mid_gated();
    test_idle_saturate();
    test_random();
    test_cnt_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
